stream_mux_nx1: RTL and testbench
=================================

// Module: stream_mux_nx1
// PURPOSE
//  Parametrised N:1 stream multiplexer; next generation of the combinational 8x1/4x1 muxes.
//  Selects one of N W-bit input channels, by external select or by round-robin arbitration.
//  Uses a valid/ready handshake and a one-stage registered output that holds its value under back-pressure.
//  Sits between channel producers and a single downstream consumer.
// PARAMETERS
//  N     8   number of input channels, N >= 2 (need not be a power of two)
//  W     1   data width per channel in bits
//  MODE  0   0 = external select (SEL_EXT), 1 = round-robin arbitration (SEL_RR)
//  SW    $clog2(N)  select/index width (derived localparam, not overridable)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_data    in   N*W   channel i occupies bits [i*W +: W]
//  in_valid   in   N     per-channel valid
//  in_ready   out  N     per-channel ready (combinational)
//  sel        in   SW    channel select; used only when MODE=0
//  out_data   out  W     registered output data
//  out_ch     out  SW    registered index of the channel that supplied out_data
//  out_valid  out  1     registered output valid
//  out_ready  in   1     downstream ready
// BEHAVIOUR
//  - Reset values (rst sampled high at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//    While rst=1, in_ready=0.
//  - accept = !out_valid || out_ready.
//    The output register loads only on a cycle where accept=1 and a channel is granted.
//  - Handshakes:
//    - Input transfer on channel i: in_valid[i] && in_ready[i].
//    - Output transfer: out_valid && out_ready.
//  - At most one in_ready bit is high per cycle: in_ready[g] = accept && granted && !rst.
//  - Latency: one clk from input transfer to out_valid=1 with the same data.
//    Full throughput: 1 beat/cycle while out_ready=1.
//  - Stall: out_valid && !out_ready keeps out_data and out_ch stable and drives in_ready=0.
//    Changes on sel or on the in_valid bits during a stall have no effect.
//  - If accept=1 and no channel is granted: out_valid goes to 0 on the next edge and out_data holds.
//  - MODE=0: grant g=sel if sel<N and in_valid[sel]=1.
//    If sel>=N: no grant, no in_ready, never X-propagates.
//  - MODE=1: g = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
//    - On an input transfer, rr_ptr <= (g+1) mod N, wrapping N-1 -> 0 for any N.
//    - rr_ptr does not change when there is no transfer.
//    - Fairness: with all N valids held high, grants cycle 0,1,...,N-1,0.
//  - Reset mid-operation: the in-flight output beat is dropped (out_valid=0 on the next edge).
//    No in_ready is asserted in the rst cycle.
//  - The input mux is one-hot AND-OR over N channels; no priority chain.
// STRUCTURE
//  - Package stream_mux_pkg holds the MODE constants: localparam SEL_EXT=0, SEL_RR=1.
//  - One sub-module, rr_arbiter_nx1 (N), with ports:
//      req[N], ptr[SW] -> gnt_onehot[N], gnt_idx[SW], any.
//    Pure combinational; rr_ptr lives in the parent.
//  - Parent contents: grant selection per MODE, data mux, output register, rr_ptr register.
// TESTING (N=8, W=1, in_data per ch0..7 = 0,0,1,0,1,0,1,1)
//  1 MODE=0, all valid, out_ready=1, sel stepped 0..7, one per cycle.
//    -> one cycle later out_data = 0,0,1,0,1,0,1,1 and out_ch = 0..7.
//  2 MODE=0, sel=2, out_ready=0 for 3 cycles, then sel=4, then out_ready=1.
//    -> out_data=1, out_ch=2 held stable; in_ready=0 throughout.
//    -> after release, next beat has out_ch=4.
//  3 MODE=1, all valid, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1.
//  4 MODE=1, in_valid=8'b1000_0100, rr_ptr=3 -> grant ch2 is wrong; expect ch7, then ch2, then ch7.
//  5 N=5, MODE=0, sel=6 -> in_ready=0 and out_valid=0.
//    MODE=1 with only ch4 valid -> grants ch4 repeatedly and rr_ptr wraps to 0.
//  6 rst=1 while out_valid=1, mid-stall -> next edge out_valid=0, out_data=0, out_ch=0.
//    in_ready=0 throughout the rst cycle.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants for the N:1 stream multiplexer.
package stream_mux_pkg;

    localparam int unsigned SEL_EXT = 0;
    localparam int unsigned SEL_RR  = 1;

endpackage

// File: rtl/rr_arbiter_nx1.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping mod N.
// The pointer register lives in the parent.
module rr_arbiter_nx1 #(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [SW-1:0] base;
    logic [SW:0]   sum;
    logic [SW-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        // An out-of-range pointer falls back to channel 0 so the scan stays inside 0..N-1.
        base       = ({1'b0, ptr} < (SW+1)'(N)) ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (SW+1)'(k);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            idx = sum[SW-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream multiplexer with external-select or round-robin grant
// and a single registered output stage that holds under back-pressure.
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N    = 8,
    parameter  int unsigned W    = 1,
    parameter  int unsigned MODE = SEL_EXT,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic          accept;
    logic [N-1:0]  ext_onehot;
    logic          ext_any;
    logic [N-1:0]  rr_onehot;
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic [N-1:0]  gnt_onehot;
    logic [SW-1:0] gnt_idx;
    logic          any;
    logic [W-1:0]  mux_data;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_ptr_next;

    assign accept = !out_valid || out_ready;

    // Matching sel against each legal index means sel >= N simply grants nothing.
    always_comb begin
        ext_onehot = '0;
        for (int i = 0; i < N; i++) begin
            ext_onehot[i] = (sel == SW'(i)) && in_valid[i];
        end
    end

    assign ext_any = |ext_onehot;

    rr_arbiter_nx1 #(
        .N (N)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .any        (rr_any)
    );

    always_comb begin
        if (MODE == SEL_RR) begin
            gnt_onehot = rr_onehot;
            gnt_idx    = rr_idx;
            any        = rr_any;
        end else begin
            gnt_onehot = ext_onehot;
            gnt_idx    = sel;
            any        = ext_any;
        end
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | ({W{gnt_onehot[i]}} & in_data[i*W +: W]);
        end
    end

    assign in_ready    = (accept && !rst) ? gnt_onehot : '0;
    assign rr_ptr_next = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_valid <= any;
                if (any) begin
                    out_data <= mux_data;
                    out_ch   <= gnt_idx;
                end
            end
            if ((MODE == SEL_RR) && accept && any) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1: four configurations (N=8/5, both modes),
// directed scenarios followed by random traffic with random resets.
module tb_stream_mux_nx1;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic chk(input int id, input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL dut%0d %s: got %0d, expected %0d", id, name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int unsigned NK  = (k < 2) ? 8 : 5;
        localparam int unsigned WK  = (k < 2) ? 1 : 3;
        localparam int unsigned MK  = (k % 2 == 0) ? SEL_EXT : SEL_RR;
        localparam int unsigned SWK = $clog2(NK);
        localparam int unsigned DW  = NK * WK;

        logic           rst;
        logic [DW-1:0]  in_data;
        logic [NK-1:0]  in_valid;
        logic [NK-1:0]  in_ready;
        logic [SWK-1:0] sel;
        logic [WK-1:0]  out_data;
        logic [SWK-1:0] out_ch;
        logic           out_valid;
        logic           out_ready;

        stream_mux_nx1 #(
            .N    (NK),
            .W    (WK),
            .MODE (MK)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .sel       (sel),
            .out_data  (out_data),
            .out_ch    (out_ch),
            .out_valid (out_valid),
            .out_ready (out_ready)
        );

        // Reference: grant is the valid channel nearest at-or-after the pointer.
        bit            m_valid = 1'b0;
        int            m_ptr   = 0;
        int            m_g;
        int            exp_ch[$];
        int            exp_data[$];
        logic [NK-1:0] exp_rdy;
        int            bits8[8] = '{0, 0, 1, 0, 1, 0, 1, 1};

        function automatic int pick(input logic [NK-1:0] v, input int s, input int p);
            int best  = -1;
            int bestd = NK;
            if (MK == SEL_EXT) begin
                return (s < NK && v[s] == 1'b1) ? s : -1;
            end
            for (int i = 0; i < NK; i++) begin
                if (v[i] && ((i - p + NK) % NK) < bestd) begin
                    best  = i;
                    bestd = (i - p + NK) % NK;
                end
            end
            return best;
        endfunction

        always_comb m_g = pick(in_valid, int'(sel), m_ptr);

        always_comb begin
            exp_rdy = '0;
            if (!rst && (!m_valid || out_ready) && m_g >= 0) begin
                exp_rdy[m_g] = 1'b1;
            end
        end

        always @(posedge clk) begin
            if (rst) begin
                m_valid <= 1'b0;
                m_ptr   <= 0;
                exp_ch.delete();
                exp_data.delete();
            end else if (!m_valid || out_ready) begin
                m_valid <= (m_g >= 0);
                if (m_g >= 0) begin
                    exp_ch.push_back(m_g);
                    exp_data.push_back(int'(in_data[m_g*WK +: WK]));
                    if (MK == SEL_RR) begin
                        m_ptr <= (m_g + 1) % NK;
                    end
                end
            end
        end

        always @(negedge clk) begin
            chk(k, "out_valid", longint'(out_valid), longint'(m_valid));
            chk(k, "in_ready", longint'(in_ready), longint'(exp_rdy));
            if (out_valid) begin
                if (exp_ch.size() == 0) begin
                    chk(k, "unexpected_beat", 1, 0);
                end else begin
                    chk(k, "out_ch", longint'(out_ch), longint'(exp_ch[0]));
                    chk(k, "out_data", longint'(out_data), longint'(exp_data[0]));
                    if (out_ready) begin
                        void'(exp_ch.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        initial begin
            int bad[3] = '{6, 5, 7};
            rst       = 1'b1;
            in_data   = '0;
            in_valid  = '0;
            sel       = '0;
            out_ready = 1'b1;
            step();
            step();
            chk(k, "rst_out_valid", longint'(out_valid), 0);
            chk(k, "rst_out_data", longint'(out_data), 0);
            chk(k, "rst_out_ch", longint'(out_ch), 0);
            rst = 1'b0;

            case (k)
                0: begin
                    in_data  = DW'(32'hD4);
                    in_valid = '1;
                    for (int s = 0; s < 8; s++) begin
                        sel = SWK'(s);
                        step();
                        chk(k, "t1_out_ch", longint'(out_ch), s);
                        chk(k, "t1_out_data", longint'(out_data), bits8[s]);
                    end
                    sel = SWK'(2);
                    step();
                    chk(k, "t2_load_ch", longint'(out_ch), 2);
                    out_ready = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        if (c == 2) sel = SWK'(4);
                        #1;
                        chk(k, "t2_stall_in_ready", longint'(in_ready), 0);
                        step();
                        chk(k, "t2_hold_ch", longint'(out_ch), 2);
                        chk(k, "t2_hold_data", longint'(out_data), 1);
                    end
                    out_ready = 1'b1;
                    step();
                    chk(k, "t2_next_ch", longint'(out_ch), 4);
                    out_ready = 1'b0;
                    step();
                    chk(k, "t6_stalled_valid", longint'(out_valid), 1);
                    rst = 1'b1;
                    #1;
                    chk(k, "t6_rst_in_ready", longint'(in_ready), 0);
                    step();
                    chk(k, "t6_out_valid", longint'(out_valid), 0);
                    chk(k, "t6_out_data", longint'(out_data), 0);
                    chk(k, "t6_out_ch", longint'(out_ch), 0);
                    rst = 1'b0;
                end
                1: begin
                    in_data  = DW'(32'hD4);
                    in_valid = '1;
                    for (int i = 0; i < 10; i++) begin
                        step();
                        chk(k, "t3_rr_ch", longint'(out_ch), i % 8);
                    end
                    step();
                    chk(k, "t4_pre_ch", longint'(out_ch), 2);
                    in_valid = NK'(32'h84);
                    step();
                    chk(k, "t4_first", longint'(out_ch), 7);
                    step();
                    chk(k, "t4_second", longint'(out_ch), 2);
                    step();
                    chk(k, "t4_third", longint'(out_ch), 7);
                end
                2: begin
                    in_data  = DW'($urandom);
                    in_valid = '1;
                    sel      = SWK'(3);
                    step();
                    chk(k, "t5_ok_valid", longint'(out_valid), 1);
                    chk(k, "t5_ok_ch", longint'(out_ch), 3);
                    for (int b = 0; b < 3; b++) begin
                        sel = SWK'(bad[b]);
                        #1;
                        chk(k, "t5_bad_in_ready", longint'(in_ready), 0);
                        step();
                        chk(k, "t5_bad_out_valid", longint'(out_valid), 0);
                    end
                end
                default: begin
                    in_data  = DW'($urandom);
                    in_valid = NK'(32'h10);
                    for (int i = 0; i < 4; i++) begin
                        step();
                        chk(k, "t5_only4_ch", longint'(out_ch), 4);
                        chk(k, "t5_only4_valid", longint'(out_valid), 1);
                    end
                    in_valid = '1;
                    step();
                    chk(k, "t5_wrap_ch", longint'(out_ch), 0);
                end
            endcase

            for (int i = 0; i < 500; i++) begin
                in_data   = DW'($urandom);
                in_valid  = (($urandom % 4) == 0) ? '1 : NK'($urandom);
                sel       = SWK'($urandom);
                out_ready = ($urandom % 4) != 0;
                rst       = ($urandom % 64) == 0;
                step();
            end
            rst       = 1'b0;
            in_valid  = '0;
            out_ready = 1'b1;
            repeat (3) step();
            n_done++;
        end
    end

    initial begin
        int cyc = 0;
        while (n_done < 4 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_done < 4) chk(-1, "timeout_done", n_done, 4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
